// File: rtl/vga_timing_ctrl.sv
// 640x480 VGA timing generator: pixel-rate divider, raw x/y scan counters and a
// registered pin stage that keeps hsync, vsync and colour on the same pixel edge.
module vga_timing_ctrl #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  rgb_in,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        pix_tick,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [7:0]  rgb_out,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0]  DIV_MAX = 4'(CLK_DIV - 1);
  localparam logic [10:0] X_MAX   = 11'(H_TOTAL - 1);
  localparam logic [10:0] Y_MAX   = 11'(V_TOTAL - 1);
  localparam logic [10:0] X_ACT   = 11'(H_ACTIVE);
  localparam logic [10:0] Y_ACT   = 11'(V_ACTIVE);
  localparam logic [10:0] HS_LO   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_HI   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_LO   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_HI   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [3:0]  r_divCnt;
  logic [10:0] r_x;
  logic [10:0] r_y;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_videoOn;
  logic [7:0]  r_rgbOut;
  logic        r_frameStart;

  logic w_tick;
  logic w_xWrap;
  logic w_yWrap;
  logic w_act;
  logic w_hs;
  logic w_vs;

  // Gated by rst_n so that CLK_DIV=1 cannot show a tick while held in reset.
  assign w_tick  = rst_n & en & (r_divCnt == DIV_MAX);
  assign w_xWrap = (r_x == X_MAX);
  assign w_yWrap = (r_y == Y_MAX);
  assign w_act   = (r_x < X_ACT) && (r_y < Y_ACT);
  assign w_hs    = !((r_x >= HS_LO) && (r_x <= HS_HI));
  assign w_vs    = !((r_y >= VS_LO) && (r_y <= VS_HI));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_divCnt <= '0;
      r_x      <= '0;
      r_y      <= '0;
    end else if (!en) begin
      r_divCnt <= '0;
      r_x      <= '0;
      r_y      <= '0;
    end else begin
      r_divCnt <= w_tick ? '0 : r_divCnt + 4'd1;
      if (w_tick) begin
        if (w_xWrap) begin
          r_x <= '0;
          r_y <= w_yWrap ? '0 : r_y + 11'd1;
        end else begin
          r_x <= r_x + 11'd1;
        end
      end
    end
  end

  // Pins show the pixel that x,y presented during the previous pixel period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_videoOn    <= 1'b0;
      r_rgbOut     <= 8'h00;
      r_frameStart <= 1'b0;
    end else if (!en) begin
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_videoOn    <= 1'b0;
      r_rgbOut     <= 8'h00;
      r_frameStart <= 1'b0;
    end else begin
      r_frameStart <= w_tick & w_xWrap & w_yWrap;
      if (w_tick) begin
        r_hsync   <= w_hs;
        r_vsync   <= w_vs;
        r_videoOn <= w_act;
        r_rgbOut  <= w_act ? rgb_in : 8'h00;
      end
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign pix_tick    = w_tick;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_videoOn;
  assign rgb_out     = r_rgbOut;
  assign frame_start = r_frameStart;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a full-size 640x480 instance checked against a pixel
// model and scoreboard, plus a tiny CLK_DIV=1 instance for whole-frame timing.
module tb_vga_timing_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, en2;
  logic [7:0]  rgb_in, rgb_in2;
  logic [10:0] x, y, x2, y2;
  logic        pix_tick, hsync, vsync, video_on, frame_start;
  logic        pix_tick2, hsync2, vsync2, video_on2, frame_start2;
  logic [7:0]  rgb_out, rgb_out2;

  vga_timing_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rgb_in(rgb_in),
    .x(x), .y(y), .pix_tick(pix_tick), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .rgb_out(rgb_out), .frame_start(frame_start)
  );

  // Tiny geometry: 15 clocks per line, 8 lines per frame, one pixel per clock.
  vga_timing_ctrl #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dutSmall (
    .clk(clk), .rst_n(rst_n), .en(en2), .rgb_in(rgb_in2),
    .x(x2), .y(y2), .pix_tick(pix_tick2), .hsync(hsync2), .vsync(vsync2),
    .video_on(video_on2), .rgb_out(rgb_out2), .frame_start(frame_start2)
  );

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       von;
    logic [7:0] rgb;
  } exp_t;

  exp_t expQ[$];
  exp_t mHeld;
  int   checks = 0;
  int   failures = 0;
  int   mDiv, mX, mY;
  logic mFs;
  int   rgbMode;
  logic [7:0] rgbConst;

  function automatic exp_t idleExp();
    exp_t e;
    e.hs = 1'b1; e.vs = 1'b1; e.von = 1'b0; e.rgb = 8'h00;
    return e;
  endfunction

  function automatic logic [7:0] rgbFor(int px);
    return (rgbMode == 1) ? 8'(px) : rgbConst;
  endfunction

  // One clock of the reference model: expected pins are queued at the tick edge
  // that samples them and retired into mHeld once that edge has passed.
  task automatic clkStep(output bit ticked);
    exp_t n;
    bit   fsNext;
    ticked = rst_n && en && (mDiv == 1);
    fsNext = ticked && (mX == 799) && (mY == 524);
    if (ticked) begin
      n.von = (mX < 640) && (mY < 480);
      n.hs  = !((mX >= 656) && (mX <= 751));
      n.vs  = !((mY >= 490) && (mY <= 491));
      n.rgb = n.von ? rgb_in : 8'h00;
      expQ.push_back(n);
    end
    @(posedge clk);
    #1;
    if (!rst_n || !en) begin
      mDiv = 0; mX = 0; mY = 0; mFs = 1'b0;
      expQ.delete();
      mHeld = idleExp();
    end else begin
      mFs = fsNext;
      if (ticked) begin
        mDiv = 0;
        if (mX == 799) begin
          mX = 0;
          mY = (mY == 524) ? 0 : mY + 1;
        end else begin
          mX = mX + 1;
        end
        if (expQ.size() > 0) mHeld = expQ.pop_front();
      end else begin
        mDiv = mDiv + 1;
      end
    end
    rgb_in = rgbFor(mX);
  endtask

  task automatic restartScan();
    bit tk;
    en = 1'b0;
    clkStep(tk);
    en = 1'b1;
    rgb_in = rgbFor(mX);
  endtask

  task automatic test_reset();
    bit tk;
    rst_n = 1'b0; en = 1'b0; en2 = 1'b1;
    rgbMode = 0; rgbConst = 8'h00; rgb_in = 8'h00; rgb_in2 = 8'h00;
    #23;
    checks++;
    if ({x, y, pix_tick, hsync, vsync, video_on, rgb_out, frame_start} !==
        {11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_state got x=%0d y=%0d tick=%b hs=%b vs=%b von=%b rgb=%h fs=%b want 0 0 0 1 1 0 00 0",
               x, y, pix_tick, hsync, vsync, video_on, rgb_out, frame_start);
    end
    checks++;
    if (pix_tick2 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_tick_div1 got %b want 0", pix_tick2);
    end
    @(negedge clk);
    en2 = 1'b0;
    rst_n = 1'b1; en = 1'b1;
    mDiv = 0; mX = 0; mY = 0; mFs = 1'b0; mHeld = idleExp(); expQ.delete();
    for (int i = 0; i < 8; i++) begin
      clkStep(tk);
      checks++;
      if ({pix_tick, x, y} !== {(mDiv == 1), 11'(mX), 11'(mY)}) begin
        failures++;
        $display("[TB] FAIL reset_run step=%0d got tick=%b x=%0d y=%0d want tick=%b x=%0d y=%0d",
                 i, pix_tick, x, y, (mDiv == 1), mX, mY);
      end
      checks++;
      if ({hsync, vsync, rgb_out} !== {1'b1, 1'b1, 8'h00}) begin
        failures++;
        $display("[TB] FAIL reset_pins step=%0d got hs=%b vs=%b rgb=%h want 1 1 00", i, hsync, vsync, rgb_out);
      end
    end
    checks++;
    if (x !== 11'd4) begin
      failures++;
      $display("[TB] FAIL reset_x_after_8clk got %0d want 4", x);
    end
  endtask

  task automatic test_line();
    bit tk;
    int hsLow = 0;
    int firstLowX = -1;
    int preX;
    rgbMode = 0; rgbConst = 8'h5A;
    restartScan();
    for (int i = 0; i < 1600; i++) begin
      preX = mX;
      clkStep(tk);
      checks++;
      if ({x, y, pix_tick, frame_start} !== {11'(mX), 11'(mY), (mDiv == 1), mFs}) begin
        failures++;
        $display("[TB] FAIL line_count clk=%0d got x=%0d y=%0d tick=%b fs=%b want x=%0d y=%0d tick=%b fs=%b",
                 i, x, y, pix_tick, frame_start, mX, mY, (mDiv == 1), mFs);
      end
      checks++;
      if ({hsync, vsync, video_on, rgb_out} !== {mHeld.hs, mHeld.vs, mHeld.von, mHeld.rgb}) begin
        failures++;
        $display("[TB] FAIL line_pins clk=%0d got hs=%b vs=%b von=%b rgb=%h want hs=%b vs=%b von=%b rgb=%h",
                 i, hsync, vsync, video_on, rgb_out, mHeld.hs, mHeld.vs, mHeld.von, mHeld.rgb);
      end
      if (tk && (hsync === 1'b0)) begin
        hsLow++;
        if (firstLowX < 0) firstLowX = preX;
      end
    end
    checks++;
    if (hsLow != 96) begin
      failures++;
      $display("[TB] FAIL hsync_width got %0d ticks want 96", hsLow);
    end
    checks++;
    if (firstLowX != 656) begin
      failures++;
      $display("[TB] FAIL hsync_start got x=%0d want 656", firstLowX);
    end
    checks++;
    if ({x, y} !== {11'd0, 11'd1}) begin
      failures++;
      $display("[TB] FAIL line_wrap got x=%0d y=%0d want 0 1", x, y);
    end
  endtask

  task automatic test_colour();
    bit tk;
    int litTicks = 0;
    rgbMode = 0; rgbConst = 8'hA5;
    restartScan();
    for (int i = 0; i < 3200; i++) begin
      clkStep(tk);
      checks++;
      if ({hsync, vsync, video_on, rgb_out} !== {mHeld.hs, mHeld.vs, mHeld.von, mHeld.rgb}) begin
        failures++;
        $display("[TB] FAIL colour_pins clk=%0d got hs=%b vs=%b von=%b rgb=%h want hs=%b vs=%b von=%b rgb=%h",
                 i, hsync, vsync, video_on, rgb_out, mHeld.hs, mHeld.vs, mHeld.von, mHeld.rgb);
      end
      checks++;
      if (rgb_out !== (video_on ? 8'hA5 : 8'h00)) begin
        failures++;
        $display("[TB] FAIL colour_blank clk=%0d got rgb=%h with von=%b", i, rgb_out, video_on);
      end
      if (tk && (rgb_out === 8'hA5)) litTicks++;
    end
    checks++;
    if (litTicks != 1280) begin
      failures++;
      $display("[TB] FAIL colour_lit_count got %0d want 1280", litTicks);
    end
  endtask

  task automatic test_align();
    bit tk;
    int preX;
    rgbMode = 1;
    restartScan();
    for (int i = 0; i < 1600; i++) begin
      preX = mX;
      clkStep(tk);
      checks++;
      if ({hsync, video_on, rgb_out} !== {mHeld.hs, mHeld.von, mHeld.rgb}) begin
        failures++;
        $display("[TB] FAIL align_pins clk=%0d got hs=%b von=%b rgb=%h want hs=%b von=%b rgb=%h",
                 i, hsync, video_on, rgb_out, mHeld.hs, mHeld.von, mHeld.rgb);
      end
      if (tk && (preX < 640)) begin
        checks++;
        if (rgb_out !== 8'(preX)) begin
          failures++;
          $display("[TB] FAIL align_lag x=%0d got rgb=%h want %h", preX, rgb_out, 8'(preX));
        end
      end
    end
  endtask

  task automatic test_disrupt();
    bit tk;
    int guard = 0;
    rgbMode = 0; rgbConst = 8'hA5;
    restartScan();
    while (!(mX == 300 && mY == 1 && mDiv == 1) && guard < 4000) begin
      clkStep(tk);
      guard++;
    end
    checks++;
    if (guard >= 4000) begin
      failures++;
      $display("[TB] FAIL disrupt_reach got guard=%0d want position x=300 y=1", guard);
    end
    checks++;
    if ({x, y, video_on, rgb_out} !== {11'd300, 11'd1, 1'b1, 8'hA5}) begin
      failures++;
      $display("[TB] FAIL disrupt_pre got x=%0d y=%0d von=%b rgb=%h want 300 1 1 a5", x, y, video_on, rgb_out);
    end
    en = 1'b0;
    clkStep(tk);
    checks++;
    if ({x, y, pix_tick, hsync, vsync, video_on, rgb_out, frame_start} !==
        {11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("[TB] FAIL en_low_clear got x=%0d y=%0d tick=%b hs=%b vs=%b von=%b rgb=%h fs=%b",
               x, y, pix_tick, hsync, vsync, video_on, rgb_out, frame_start);
    end
    en = 1'b1;
    clkStep(tk);
    checks++;
    if ({pix_tick, x} !== {1'b1, 11'd0}) begin
      failures++;
      $display("[TB] FAIL en_rise_first got tick=%b x=%0d want 1 0", pix_tick, x);
    end
    clkStep(tk);
    checks++;
    if ({pix_tick, x} !== {1'b0, 11'd1}) begin
      failures++;
      $display("[TB] FAIL en_rise_second got tick=%b x=%0d want 0 1", pix_tick, x);
    end
    for (int i = 0; i < 100; i++) clkStep(tk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({x, y, pix_tick, hsync, vsync, video_on, rgb_out, frame_start} !==
        {11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("[TB] FAIL async_reset got x=%0d y=%0d tick=%b hs=%b vs=%b von=%b rgb=%h fs=%b",
               x, y, pix_tick, hsync, vsync, video_on, rgb_out, frame_start);
    end
    clkStep(tk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) clkStep(tk);
    checks++;
    if ({x, y, video_on, rgb_out} !== {11'd2, 11'd0, 1'b1, 8'hA5}) begin
      failures++;
      $display("[TB] FAIL reset_restart got x=%0d y=%0d von=%b rgb=%h want 2 0 1 a5", x, y, video_on, rgb_out);
    end
  endtask

  task automatic test_clkdiv1();
    int sx = 0, sy = 0;
    int fsCount = 0, vsLow = 0, firstVsY = -1;
    logic eHs, eVs, eVon, eFs;
    logic [7:0] eRgb;
    rgb_in2 = 8'h3C;
    en2 = 1'b1;
    #1;
    checks++;
    if (pix_tick2 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL div1_first_tick got %b want 1", pix_tick2);
    end
    for (int i = 0; i < 240; i++) begin
      eHs  = !((sx >= 10) && (sx <= 12));
      eVs  = !((sy >= 5) && (sy <= 6));
      eVon = (sx < 8) && (sy < 4);
      eRgb = eVon ? 8'h3C : 8'h00;
      eFs  = (sx == 14) && (sy == 7);
      if (sx == 14) begin
        sx = 0;
        sy = (sy == 7) ? 0 : sy + 1;
      end else begin
        sx = sx + 1;
      end
      @(posedge clk);
      #1;
      checks++;
      if ({x2, y2, pix_tick2, hsync2, vsync2, video_on2, rgb_out2, frame_start2} !==
          {11'(sx), 11'(sy), 1'b1, eHs, eVs, eVon, eRgb, eFs}) begin
        failures++;
        $display("[TB] FAIL div1_step clk=%0d got x=%0d y=%0d tick=%b hs=%b vs=%b von=%b rgb=%h fs=%b want x=%0d y=%0d tick=1 hs=%b vs=%b von=%b rgb=%h fs=%b",
                 i, x2, y2, pix_tick2, hsync2, vsync2, video_on2, rgb_out2, frame_start2,
                 sx, sy, eHs, eVs, eVon, eRgb, eFs);
      end
      if (frame_start2 === 1'b1) fsCount++;
      if (vsync2 === 1'b0) begin
        vsLow++;
        if (firstVsY < 0) firstVsY = (sx == 0) ? ((sy == 0) ? 7 : sy - 1) : sy;
      end
    end
    checks++;
    if (fsCount != 2) begin
      failures++;
      $display("[TB] FAIL div1_frame_count got %0d want 2", fsCount);
    end
    checks++;
    if (vsLow != 60) begin
      failures++;
      $display("[TB] FAIL div1_vsync_width got %0d clks want 60", vsLow);
    end
    checks++;
    if (firstVsY != 5) begin
      failures++;
      $display("[TB] FAIL div1_vsync_start got y=%0d want 5", firstVsY);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_line();
    test_colour();
    test_align();
    test_disrupt();
    test_clkdiv1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
